// File: rtl/beep_pkg.sv
// Shared FSM encoding, default timing constants and counter sizing helper
// for the beep_pattern buzzer sequencer.
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Defaults give a 500 Hz tone with 0.5 s bursts and gaps at a 1 kHz clock
  localparam int unsigned DEF_TONE_HALF = 1;
  localparam int unsigned DEF_ON_CYC    = 500;
  localparam int unsigned DEF_OFF_CYC   = 500;
  localparam int unsigned DEF_NB_W      = 4;

  // Bits needed for a counter running 0 .. max_val-1, never less than one bit
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/beep_pattern_tone_div.sv
// Square-wave tone generator: high on the first enabled cycle after a
// phase restart, then toggling every TONE_HALF cycles; low when disabled.
module tone_div
  import beep_pkg::*;
#(
  parameter int unsigned TONE_HALF = DEF_TONE_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tone
);

  localparam int unsigned CW = cnt_w(TONE_HALF);
  localparam logic [CW-1:0] HALF_LAST = CW'(TONE_HALF - 1);

  logic [CW-1:0] cnt;

  // Half-period counter and tone register; restart wins over running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tone <= 1'b1;
    end else if (en) begin
      if (cnt == HALF_LAST) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt  <= '0;
      tone <= 1'b0;
    end
  end

endmodule

// File: rtl/beep_pattern.sv
// Buzzer pattern sequencer: on start, emits n_beeps tone bursts separated by
// silent gaps, then pulses over for one cycle.
// Optional feature macro: BEEP_PATTERN_ABORT_EN adds an abort input that cuts
// a running pattern short (straight to the completion cycle).
module beep_pattern
  import beep_pkg::*;
#(
  parameter int unsigned TONE_HALF = DEF_TONE_HALF,
  parameter int unsigned ON_CYC    = DEF_ON_CYC,
  parameter int unsigned OFF_CYC   = DEF_OFF_CYC,
  parameter int unsigned NB_W      = DEF_NB_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st,
  input  logic [NB_W-1:0] n_beeps,
`ifdef BEEP_PATTERN_ABORT_EN
  input  logic            abort,
`endif
  output logic            beep,
  output logic            busy,
  output logic            over
);

  localparam int unsigned DW = cnt_w((ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC);
  localparam logic [DW-1:0] ON_LAST  = DW'(ON_CYC - 1);
  localparam logic [DW-1:0] OFF_LAST = DW'(OFF_CYC - 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   dur_q, dur_d;
  logic [NB_W-1:0] rem_q, rem_d;
  logic            abort_c;
  logic            tone_en_c;
  logic            tone_restart_c;

`ifdef BEEP_PATTERN_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // State, burst-duration counter and remaining-burst count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dur_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic; rem counts bursts still to come after the current one
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        dur_d = '0;
        if (st) begin
          if (n_beeps == '0) begin
            state_d = DONE;
            rem_d   = '0;
          end else begin
            state_d = ON;
            rem_d   = n_beeps - NB_W'(1);
          end
        end
      end
      ON: begin
        if (abort_c) begin
          state_d = DONE;
          dur_d   = '0;
          rem_d   = '0;
        end else if (dur_q == ON_LAST) begin
          dur_d   = '0;
          state_d = (rem_q != '0) ? OFF : DONE;
        end else begin
          dur_d = dur_q + DW'(1);
        end
      end
      OFF: begin
        if (abort_c) begin
          state_d = DONE;
          dur_d   = '0;
          rem_d   = '0;
        end else if (dur_q == OFF_LAST) begin
          dur_d   = '0;
          rem_d   = rem_q - NB_W'(1);
          state_d = ON;
        end else begin
          dur_d = dur_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        dur_d   = '0;
        rem_d   = '0;
      end
      default: begin
        state_d = IDLE;
        dur_d   = '0;
        rem_d   = '0;
      end
    endcase
  end

  // Tone runs only in ON and restarts its phase on every ON entry
  assign tone_en_c      = (state_d == ON);
  assign tone_restart_c = (state_d == ON) && (state_q != ON);

  tone_div #(
    .TONE_HALF (TONE_HALF)
  ) u_tone_div (
    .clk     (clk),
    .rst     (rst),
    .en      (tone_en_c),
    .restart (tone_restart_c),
    .tone    (beep)
  );

  // Status outputs registered from the next state so they align with beep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      over <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      over <= (state_d == DONE);
    end
  end

endmodule
